// File: rtl/serial_frame_rx_n_pkg.sv
// Shared definitions for the serial frame link: receiver state encodings,
// frame bit constants and the frame-length helper used by both link ends.
package serial_frame_rx_n_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DATA   = 3'd1,
    ST_PARITY = 3'd2,
    ST_STOP   = 3'd3,
    ST_BREAK  = 3'd4
  } rx_state_t;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  // Total bits on the line for one frame: start + data + optional parity + stop.
  function automatic int frame_len(input int n, input int parity_en);
    return n + 2 + parity_en;
  endfunction

endpackage

// File: rtl/serial_frame_rx_n_shift.sv
// N-bit right-shift register; new bits enter at the MSB so an LSB-first
// stream ends up in natural bit order after N shifts.
module serial_rx_shift_n #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         reset_p,
  input  logic         shift_en,
  input  logic         d_in,
  output logic [N-1:0] q
);

  // Shift one bit in from the top when enabled.
  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p)
      q <= '0;
    else if (shift_en)
      q <= {d_in, q[N-1:1]};
  end

endmodule

// File: rtl/serial_frame_rx_n.sv
// Serial frame receiver: start bit, N data bits LSB-first, optional even
// parity, stop bit. Received words land in a one-entry buffer with a
// valid/read handshake.
//
//  state     | meaning
//  ----------+-------------------------------------------------
//  ST_IDLE   | line idle, waiting for a start bit
//  ST_DATA   | shifting in data bits
//  ST_PARITY | sampling the parity bit
//  ST_STOP   | sampling the stop bit
//  ST_BREAK  | bad stop seen, waiting for the line to return high
module serial_frame_rx_n
  import serial_frame_rx_n_pkg::*;
#(
  parameter int N         = 8,
  parameter int PARITY_EN = 1
) (
  input  logic         clk,
  input  logic         reset_p,
  input  logic         rx_d,
  input  logic         bit_en,
  input  logic         rd_en,
  output logic [N-1:0] data_out,
  output logic         data_valid,
  output logic         parity_err,
  output logic         frame_err,
  output logic         overrun,
  output logic         busy
);

  localparam int            CW       = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

  rx_state_t     state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic          perr, perr_d;
  logic          shift_en;
  logic          good_done;
  logic          stop_bad;
  logic [N-1:0]  sh;

  serial_rx_shift_n #(.N(N)) u_shift (
    .clk      (clk),
    .reset_p  (reset_p),
    .shift_en (shift_en),
    .d_in     (rx_d),
    .q        (sh)
  );

  // State, bit counter and parity result registers.
  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      state <= ST_IDLE;
      cnt   <= '0;
      perr  <= 1'b0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      perr  <= perr_d;
    end
  end

  // Next-state decode; everything advances only on bit strobes.
  always_comb begin
    state_d   = state;
    cnt_d     = cnt;
    perr_d    = perr;
    shift_en  = 1'b0;
    good_done = 1'b0;
    stop_bad  = 1'b0;
    if (bit_en) begin
      case (state)
        ST_IDLE: begin
          if (rx_d == START_BIT) begin
            state_d = ST_DATA;
            cnt_d   = '0;
            perr_d  = 1'b0;
          end
        end
        ST_DATA: begin
          shift_en = 1'b1;
          cnt_d    = cnt + 1'b1;
          if (cnt == CNT_LAST) begin
            cnt_d   = '0;
            state_d = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
          end
        end
        ST_PARITY: begin
          perr_d  = ^{sh, rx_d};
          state_d = ST_STOP;
        end
        ST_STOP: begin
          if (rx_d == STOP_BIT) begin
            good_done = 1'b1;
            state_d   = ST_IDLE;
          end else begin
            stop_bad = 1'b1;
            state_d  = ST_BREAK;
          end
        end
        ST_BREAK: begin
          if (rx_d == STOP_BIT)
            state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // One-entry output buffer plus the error/overrun pulses.
  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      data_out   <= '0;
      data_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      frame_err <= stop_bad;
      overrun   <= 1'b0;
      if (good_done) begin
        if (!data_valid || rd_en) begin
          data_out   <= sh;
          parity_err <= (PARITY_EN != 0) ? perr : 1'b0;
          data_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (rd_en && data_valid) begin
        data_valid <= 1'b0;
      end
    end
  end

  assign busy = (state != ST_IDLE);

endmodule
